// File: rtl/freqdiv_prog.sv
// Programmable square-wave / tick divider: clkout toggles every hp_q+1 enabled clkin cycles.
// Divisor changes are held in a pending register and applied only at a toggle boundary.
module freqdiv_prog #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned P0    = 50000000,
  parameter int unsigned P1    = 150000000,
  parameter int unsigned P2    = 25000000
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             clkout,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] P0_C = CNT_W'(P0);
  localparam logic [CNT_W-1:0] P1_C = CNT_W'(P1);
  localparam logic [CNT_W-1:0] P2_C = CNT_W'(P2);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [CNT_W-1:0] cont_q, cont_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] cust_q, cust_d;
  logic [CNT_W-1:0] nxt_q, nxt_d;
  logic [0:0]       state_q, state_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] target;
  logic             boundary;

  always_comb begin
    case (sel)
      2'b00:   target = P0_C;
      2'b01:   target = P1_C;
      2'b10:   target = P2_C;
      default: target = cust_q;
    endcase
  end

  assign boundary  = en && (cont_q == hp_q);
  assign cfg_ready = (state_q == ST_RUN);
  assign pending   = (state_q == ST_PEND);
  assign clkout    = clkout_q;
  assign tick      = tick_q;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through this block infers a latch.
    cont_d   = cont_q;
    clkout_d = clkout_q;
    tick_d   = 1'b0;
    hp_d     = hp_q;
    cust_d   = cust_q;
    nxt_d    = nxt_q;
    state_d  = state_q;

    if (en) begin
      if (cont_q == hp_q) begin
        cont_d   = '0;
        clkout_d = ~clkout_q;
        tick_d   = 1'b1;
      end else begin
        cont_d = cont_q + CNT_W'(1);
      end
    end

    if (cfg_valid && cfg_ready) begin
      cust_d = cfg_data;
    end

    // hp_q only moves while cont is being cleared, so cont can never run past it.
    case (state_q)
      ST_RUN: begin
        if (target != hp_q) begin
          nxt_d   = target;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        nxt_d = target;
        if (boundary) begin
          hp_d    = nxt_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clkin) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      cont_q   <= '0;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
      hp_q     <= P0_C;
      cust_q   <= P0_C;
      nxt_q    <= P0_C;
      state_q  <= ST_RUN;
    end else begin
      cont_q   <= cont_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
      hp_q     <= hp_d;
      cust_q   <= cust_d;
      nxt_q    <= nxt_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_freqdiv_prog.sv
// Directed bench for freqdiv_prog with small presets (P0=3, P1=5, P2=1) so every boundary is reachable quickly.
module tb_freqdiv_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] sel;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       clkout;
  logic       tick;
  logic       pending;

  int checks = 0;
  int errors = 0;

  freqdiv_prog #(.CNT_W(8), .P0(3), .P1(5), .P2(1)) dut (
    .clkin    (clk),
    .reset    (reset),
    .en       (en),
    .sel      (sel),
    .cfg_valid(cfg_valid),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready),
    .clkout   (clkout),
    .tick     (tick),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and new inputs applied 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; sel = 2'b00; cfg_valid = 1'b0; cfg_data = 8'd0;
    step(); step();
    checks++; if (clkout !== 1'b0)    begin errors++; $display("FAIL reset_clkout: got %0d want 0", clkout); end
    checks++; if (tick !== 1'b0)      begin errors++; $display("FAIL reset_tick: got %0d want 0", tick); end
    checks++; if (pending !== 1'b0)   begin errors++; $display("FAIL reset_pending: got %0d want 0", pending); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %0d want 1", cfg_ready); end
    checks++; if (dut.cont_q !== 8'd0) begin errors++; $display("FAIL reset_cont: got %0d want 0", dut.cont_q); end
    checks++; if (dut.hp_q !== 8'd3)  begin errors++; $display("FAIL reset_hp: got %0d want 3", dut.hp_q); end
  endtask

  // hp=3: toggle every 4 cycles.
  task automatic test_preset_p0();
    reset = 1'b0; en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++; if (tick !== logic'(i % 4 == 0)) begin errors++; $display("FAIL p0_tick[%0d]: got %0d want %0d", i, tick, (i % 4 == 0)); end
      checks++; if (clkout !== logic'((i / 4) % 2)) begin errors++; $display("FAIL p0_clkout[%0d]: got %0d want %0d", i, clkout, (i / 4) % 2); end
    end
  endtask

  // Switch to P1 at cont=1: pending through cont=2,3, then 6-cycle half-periods.
  task automatic test_switch_p1();
    step();
    checks++; if (dut.cont_q !== 8'd1) begin errors++; $display("FAIL sw_cont_start: got %0d want 1", dut.cont_q); end
    sel = 2'b01;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL sw_pending[%0d]: got %0d want 1", i, pending); end
      checks++; if (tick !== 1'b0)    begin errors++; $display("FAIL sw_tick_early[%0d]: got %0d want 0", i, tick); end
    end
    step();
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL sw_pending_clear: got %0d want 0", pending); end
    checks++; if (tick !== 1'b1)    begin errors++; $display("FAIL sw_boundary_tick: got %0d want 1", tick); end
    checks++; if (clkout !== 1'b1)  begin errors++; $display("FAIL sw_boundary_clkout: got %0d want 1", clkout); end
    checks++; if (dut.hp_q !== 8'd5) begin errors++; $display("FAIL sw_hp: got %0d want 5", dut.hp_q); end
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++; if (tick !== logic'(i % 6 == 0)) begin errors++; $display("FAIL p1_tick[%0d]: got %0d want %0d", i, tick, (i % 6 == 0)); end
      checks++; if (clkout !== logic'(1 ^ ((i / 6) % 2))) begin errors++; $display("FAIL p1_clkout[%0d]: got %0d want %0d", i, clkout, 1 ^ ((i / 6) % 2)); end
    end
  endtask

  // Load custom hp=0, select it: after the boundary clkout toggles every cycle.
  task automatic test_custom_zero();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cust_ready: got %0d want 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_data = 8'd0;
    step();
    cfg_valid = 1'b0;
    checks++; if (dut.cust_q !== 8'd0) begin errors++; $display("FAIL cust_value: got %0d want 0", dut.cust_q); end
    sel = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL cust_pending[%0d]: got %0d want 1", i, pending); end
      checks++; if (tick !== 1'b0)    begin errors++; $display("FAIL cust_tick_early[%0d]: got %0d want 0", i, tick); end
    end
    step();
    checks++; if (tick !== 1'b1)    begin errors++; $display("FAIL cust_boundary_tick: got %0d want 1", tick); end
    checks++; if (clkout !== 1'b0)  begin errors++; $display("FAIL cust_boundary_clkout: got %0d want 0", clkout); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL cust_boundary_pending: got %0d want 0", pending); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL div2_tick[%0d]: got %0d want 1", i, tick); end
      checks++; if (clkout !== logic'(i % 2)) begin errors++; $display("FAIL div2_clkout[%0d]: got %0d want %0d", i, clkout, i % 2); end
    end
  endtask

  // While pending: cfg writes refused, last selected target (P2=1) is the one applied.
  task automatic test_pend_last_wins();
    sel = 2'b01;
    step();
    checks++; if (tick !== 1'b1 || clkout !== 1'b1) begin errors++; $display("FAIL pend_simul_toggle: got tick=%0d clkout=%0d want 1/1", tick, clkout); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pend_enter: got %0d want 1", pending); end
    en = 1'b0; cfg_valid = 1'b1; cfg_data = 8'd7;
    step();
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL pend_cfg_ready: got %0d want 0", cfg_ready); end
    checks++; if (tick !== 1'b0 || clkout !== 1'b1) begin errors++; $display("FAIL pend_frozen: got tick=%0d clkout=%0d want 0/1", tick, clkout); end
    cfg_valid = 1'b0; sel = 2'b10;
    step();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pend_hold: got %0d want 1", pending); end
    en = 1'b1;
    step();
    checks++; if (dut.hp_q !== 8'd1) begin errors++; $display("FAIL pend_last_wins_hp: got %0d want 1", dut.hp_q); end
    checks++; if (tick !== 1'b1 || clkout !== 1'b0) begin errors++; $display("FAIL pend_boundary: got tick=%0d clkout=%0d want 1/0", tick, clkout); end
    checks++; if (dut.cust_q !== 8'd0) begin errors++; $display("FAIL pend_cfg_ignored: got %0d want 0", dut.cust_q); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (tick !== logic'(i % 2 == 0)) begin errors++; $display("FAIL p2_tick[%0d]: got %0d want %0d", i, tick, (i % 2 == 0)); end
      checks++; if (clkout !== logic'((i / 2) % 2)) begin errors++; $display("FAIL p2_clkout[%0d]: got %0d want %0d", i, clkout, (i / 2) % 2); end
    end
  endtask

  // Back to P0, freeze at cont=2 for 10 cycles, then resume.
  task automatic test_enable_freeze();
    sel = 2'b00;
    step(); step();
    checks++; if (tick !== 1'b1 || clkout !== 1'b1 || dut.hp_q !== 8'd3) begin
      errors++; $display("FAIL frz_reload: got tick=%0d clkout=%0d hp=%0d want 1/1/3", tick, clkout, dut.hp_q);
    end
    step(); step();
    checks++; if (dut.cont_q !== 8'd2) begin errors++; $display("FAIL frz_cont_start: got %0d want 2", dut.cont_q); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (tick !== 1'b0 || clkout !== 1'b1 || dut.cont_q !== 8'd2) begin
        errors++; $display("FAIL frz_hold[%0d]: got tick=%0d clkout=%0d cont=%0d want 0/1/2", i, tick, clkout, dut.cont_q);
      end
    end
    en = 1'b1;
    step();
    checks++; if (tick !== 1'b0 || dut.cont_q !== 8'd3) begin errors++; $display("FAIL frz_resume: got tick=%0d cont=%0d want 0/3", tick, dut.cont_q); end
    step();
    checks++; if (tick !== 1'b1 || clkout !== 1'b0) begin errors++; $display("FAIL frz_boundary: got tick=%0d clkout=%0d want 1/0", tick, clkout); end
  endtask

  // Reset while pending with clkout high returns everything to defaults on the next edge.
  task automatic test_reset_in_pend();
    step(); step(); step(); step();
    checks++; if (clkout !== 1'b1) begin errors++; $display("FAIL rp_clkout_high: got %0d want 1", clkout); end
    sel = 2'b01;
    step();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rp_pending: got %0d want 1", pending); end
    reset = 1'b1; cfg_valid = 1'b1; cfg_data = 8'd9;
    step();
    checks++; if (clkout !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL rp_out: got clkout=%0d tick=%0d want 0/0", clkout, tick); end
    checks++; if (pending !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL rp_fsm: got pending=%0d ready=%0d want 0/1", pending, cfg_ready); end
    checks++; if (dut.cont_q !== 8'd0 || dut.hp_q !== 8'd3 || dut.cust_q !== 8'd3) begin
      errors++; $display("FAIL rp_regs: got cont=%0d hp=%0d cust=%0d want 0/3/3", dut.cont_q, dut.hp_q, dut.cust_q);
    end
    reset = 1'b0; cfg_valid = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_preset_p0();
    test_switch_p1();
    test_custom_zero();
    test_pend_last_wins();
    test_enable_freeze();
    test_reset_in_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
